// File: rtl/apb_slave.sv
// apb_slave: APB3 completer backed by a word-addressed register memory.
// A 32-bit byte address selects one of DEPTH words. Misaligned or
// out-of-range addresses finish with pslverr. WAIT_STATES adds extra
// ACCESS cycles before pready rises.
// Optional feature: define APB_SLV_WPROT_EN to make the top quarter of
// memory read-only. A write there ends with pslverr and memory is left
// unchanged.
// Timing: the setup cycle is decoded from the bus while the FSM is IDLE.
// pready, pslverr and prdata are computed on the edge that closes the
// setup cycle, or on a wait-state edge. This lets them be registered and
// still be valid in the completion cycle.
module apb_slave #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_n;
    state_t        phase_s;
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_n;
    logic          pready_r;
    logic          pready_n;
    logic          pslverr_r;
    logic          pslverr_n;
    logic [31:0]   prdata_r;
    logic [31:0]   prdata_n;
    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] idx_s;
    logic          prot_s;
    logic          err_s;
    logic [31:0]   rd_word_s;
    logic          wr_en_s;

    // Word aligned and inside the DEPTH*4-byte window.
    function automatic logic addr_valid(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> (AW + 2)) == 32'd0);
    endfunction

    assign idx_s = paddr[2 +: AW];

`ifdef APB_SLV_WPROT_EN
    localparam logic [AW-1:0] PROT_BASE = AW'(3 * DEPTH / 4);
    assign prot_s = pwrite && (idx_s >= PROT_BASE);
`else
    assign prot_s = 1'b0;
`endif

    assign err_s = !addr_valid(paddr) || prot_s;

    // Read word for the current address; errors return zero.
    always_comb begin
        rd_word_s = 32'd0;
        if (err_s) begin
            rd_word_s = 32'd0;
        end else begin
            rd_word_s = mem_r[idx_s];
        end
    end

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        pready_n  = 1'b0;
        pslverr_n = 1'b0;
        prdata_n  = prdata_r;
        wr_en_s   = 1'b0;
        if ((state_r == IDLE) && psel && !penable) begin
            phase_s = SETUP;
        end else begin
            phase_s = state_r;
        end
        case (phase_s)
            IDLE: begin
                state_n = IDLE;
            end
            SETUP: begin
                state_n = ACCESS;
                cnt_n   = WS_LOAD;
                if (WS_LOAD == 4'd0) begin
                    pready_n  = 1'b1;
                    pslverr_n = err_s;
                    if (!pwrite || err_s) begin
                        prdata_n = rd_word_s;
                    end else begin
                        prdata_n = prdata_r;
                    end
                end else begin
                    pready_n = 1'b0;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    // Requester abandoned the transfer: no write, no response.
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else if (pready_r) begin
                    if (penable) begin
                        wr_en_s = pwrite && !err_s;
                        state_n = IDLE;
                    end else begin
                        pready_n  = 1'b1;
                        pslverr_n = pslverr_r;
                        state_n   = ACCESS;
                    end
                end else if (cnt_r <= 4'd1) begin
                    cnt_n     = 4'd0;
                    pready_n  = 1'b1;
                    pslverr_n = err_s;
                    if (!pwrite || err_s) begin
                        prdata_n = rd_word_s;
                    end else begin
                        prdata_n = prdata_r;
                    end
                end else begin
                    cnt_n = cnt_r - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // FSM state, wait counter and registered bus outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= 32'd0;
        end else begin
            state_r   <= state_n;
            cnt_r     <= cnt_n;
            pready_r  <= pready_n;
            pslverr_r <= pslverr_n;
            prdata_r  <= prdata_n;
        end
    end

    // Storage array: cleared on reset, written on the closing edge of a good write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (wr_en_s) begin
            mem_r[idx_s] <= pwdata;
        end
    end

    assign prdata  = prdata_r;
    assign pready  = pready_r;
    assign pslverr = pslverr_r;

endmodule

// File: tb/tb_apb_slave.sv
module tb_apb_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        psel0 = 1'b0;
    logic        psel3 = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic [31:0] pwdata = 32'd0;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    apb_slave #(.DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_slave #(.DEPTH(256), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .psel(psel3), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
    );

    // One transfer on the selected instance. Returns at the negedge of the completion cycle.
    // The next call starts a back-to-back setup; bus_idle() inserts an idle.
    task automatic xfer(input bit slow, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic err, output int waits);
        bit done;
        @(posedge clk); #1;
        psel0 = !slow; psel3 = slow; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = wd;
        @(negedge clk);
        n_checks++;
        if ((slow ? pready3 : pready0) !== 1'b0)
            $display("FAIL setup_pready addr=%h: got %b expected 0", addr, slow ? pready3 : pready0);
        else n_pass++;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0; rd = 32'd0; err = 1'b0; done = 1'b0;
        while (!done && waits <= 40) begin
            @(negedge clk);
            if ((slow ? pready3 : pready0) === 1'b1) begin
                rd   = slow ? prdata3 : prdata0;
                err  = slow ? pslverr3 : pslverr0;
                done = 1'b1;
            end else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        if (!done) waits = -1;
    endtask

    task automatic bus_idle();
        @(posedge clk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic err; int w;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({pready0, pslverr0, prdata0} !== 34'd0)
            $display("FAIL reset_ws0: got %h expected 0", {pready0, pslverr0, prdata0});
        else n_pass++;
        n_checks++;
        if ({pready3, pslverr3, prdata3} !== 34'd0)
            $display("FAIL reset_ws3: got %h expected 0", {pready3, pslverr3, prdata3});
        else n_pass++;
        rst = 1'b1;
        xfer(1'b0, 1'b0, 32'h0, 32'h0, rd, err, w);
        bus_idle();
        n_checks++;
        if (w !== 0 || rd !== 32'h0 || err !== 1'b0)
            $display("FAIL reset_read0: got waits=%0d data=%h err=%b expected 0/00000000/0", w, rd, err);
        else n_pass++;
    endtask

    task automatic test_basic_rw();
        logic [31:0] rd; logic err; int w;
        xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd, err, w);
        bus_idle();
        n_checks++;
        if (w !== 0 || err !== 1'b0)
            $display("FAIL ws0_write: got waits=%0d err=%b expected 0/0", w, err);
        else n_pass++;
        xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, err, w);
        bus_idle();
        n_checks++;
        if (w !== 0 || rd !== 32'hDEADBEEF || err !== 1'b0)
            $display("FAIL ws0_read: got waits=%0d data=%h err=%b expected 0/deadbeef/0", w, rd, err);
        else n_pass++;
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic err; int w;
        xfer(1'b1, 1'b1, 32'h10, 32'hCAFEF00D, rd, err, w);
        bus_idle();
        n_checks++;
        if (w !== 3 || err !== 1'b0)
            $display("FAIL ws3_write: got waits=%0d err=%b expected 3/0", w, err);
        else n_pass++;
        xfer(1'b1, 1'b0, 32'h10, 32'h0, rd, err, w);
        bus_idle();
        n_checks++;
        if (w !== 3 || rd !== 32'hCAFEF00D || err !== 1'b0)
            $display("FAIL ws3_read: got waits=%0d data=%h err=%b expected 3/cafef00d/0", w, rd, err);
        else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int w;
        xfer(1'b0, 1'b1, 32'h400, 32'h11111111, rd, err, w);
        bus_idle();
        n_checks++;
        if (w !== 0 || err !== 1'b1)
            $display("FAIL err_range_write: got waits=%0d err=%b expected 0/1", w, err);
        else n_pass++;
        xfer(1'b0, 1'b1, 32'h13, 32'h22222222, rd, err, w);
        bus_idle();
        n_checks++;
        if (w !== 0 || err !== 1'b1)
            $display("FAIL err_misaligned_write: got waits=%0d err=%b expected 0/1", w, err);
        else n_pass++;
        xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, err, w);
        bus_idle();
        n_checks++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0)
            $display("FAIL err_unchanged: got data=%h err=%b expected deadbeef/0", rd, err);
        else n_pass++;
        xfer(1'b0, 1'b0, 32'h400, 32'h0, rd, err, w);
        bus_idle();
        n_checks++;
        if (rd !== 32'h0 || err !== 1'b1)
            $display("FAIL err_range_read: got data=%h err=%b expected 00000000/1", rd, err);
        else n_pass++;
        xfer(1'b0, 1'b0, 32'h3FC, 32'h0, rd, err, w);
        bus_idle();
        n_checks++;
        if (rd !== 32'h0 || err !== 1'b0)
            $display("FAIL last_word_read: got data=%h err=%b expected 00000000/0", rd, err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd_a, rd_b; logic err_a, err_b; int wa, wb;
        xfer(1'b0, 1'b1, 32'h20, 32'h01234567, rd_a, err_a, wa);
        xfer(1'b0, 1'b1, 32'h24, 32'h89ABCDEF, rd_b, err_b, wb);
        n_checks++;
        if (wa !== 0 || wb !== 0 || err_a !== 1'b0 || err_b !== 1'b0)
            $display("FAIL b2b_writes: got waits=%0d/%0d err=%b/%b expected 0/0 0/0", wa, wb, err_a, err_b);
        else n_pass++;
        xfer(1'b0, 1'b0, 32'h20, 32'h0, rd_a, err_a, wa);
        xfer(1'b0, 1'b0, 32'h24, 32'h0, rd_b, err_b, wb);
        bus_idle();
        n_checks++;
        if (rd_a !== 32'h01234567 || rd_b !== 32'h89ABCDEF)
            $display("FAIL b2b_reads: got %h/%h expected 01234567/89abcdef", rd_a, rd_b);
        else n_pass++;
    endtask

    task automatic test_wprot();
        logic [31:0] rd; logic err; int w;
        xfer(1'b0, 1'b1, 32'h300, 32'h12345678, rd, err, w);
        bus_idle();
`ifdef APB_SLV_WPROT_EN
        n_checks++;
        if (err !== 1'b1)
            $display("FAIL wprot_write_err: got %b expected 1", err);
        else n_pass++;
        xfer(1'b0, 1'b0, 32'h300, 32'h0, rd, err, w);
        bus_idle();
        n_checks++;
        if (rd !== 32'h0 || err !== 1'b0)
            $display("FAIL wprot_read: got data=%h err=%b expected 00000000/0", rd, err);
        else n_pass++;
`else
        n_checks++;
        if (err !== 1'b0)
            $display("FAIL top_write_err: got %b expected 0", err);
        else n_pass++;
        xfer(1'b0, 1'b0, 32'h300, 32'h0, rd, err, w);
        bus_idle();
        n_checks++;
        if (rd !== 32'h12345678 || err !== 1'b0)
            $display("FAIL top_read: got data=%h err=%b expected 12345678/0", rd, err);
        else n_pass++;
`endif
        xfer(1'b0, 1'b1, 32'h2FC, 32'h0BADF00D, rd, err, w);
        bus_idle();
        n_checks++;
        if (err !== 1'b0)
            $display("FAIL below_prot_write: got err=%b expected 0", err);
        else n_pass++;
        xfer(1'b0, 1'b0, 32'h2FC, 32'h0, rd, err, w);
        bus_idle();
        n_checks++;
        if (rd !== 32'h0BADF00D || err !== 1'b0)
            $display("FAIL below_prot_read: got data=%h err=%b expected 0badf00d/0", rd, err);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int w; int highs;
        @(posedge clk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40; pwdata = 32'h55AA55AA;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel3 = 1'b0; penable = 1'b0;
        highs = 0;
        repeat (5) begin
            @(negedge clk);
            if (pready3 !== 1'b0) highs++;
        end
        n_checks++;
        if (highs !== 0)
            $display("FAIL abort_pready: got %0d cycles high expected 0", highs);
        else n_pass++;
        xfer(1'b1, 1'b0, 32'h40, 32'h0, rd, err, w);
        bus_idle();
        n_checks++;
        if (rd !== 32'h0 || err !== 1'b0 || w !== 3)
            $display("FAIL abort_no_write: got data=%h err=%b waits=%0d expected 00000000/0/3", rd, err, w);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int w;
        xfer(1'b1, 1'b0, 32'h10, 32'h0, rd, err, w);
        n_checks++;
        if (rd !== 32'hCAFEF00D)
            $display("FAIL pre_reset_read: got %h expected cafef00d", rd);
        else n_pass++;
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({pready3, pslverr3, prdata3} !== 34'd0)
            $display("FAIL mid_reset_outputs: got %h expected 0", {pready3, pslverr3, prdata3});
        else n_pass++;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        xfer(1'b1, 1'b0, 32'h10, 32'h0, rd, err, w);
        bus_idle();
        n_checks++;
        if (rd !== 32'h0 || err !== 1'b0)
            $display("FAIL ws3_mem_cleared: got data=%h err=%b expected 00000000/0", rd, err);
        else n_pass++;
        xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, err, w);
        bus_idle();
        n_checks++;
        if (rd !== 32'h0 || err !== 1'b0)
            $display("FAIL ws0_mem_cleared: got data=%h err=%b expected 00000000/0", rd, err);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_rw();
        test_wait_states();
        test_errors();
        test_back_to_back();
        test_wprot();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
